// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse bring-up (reset, BAT, ID, enable streaming) and 3-byte packet
// decoding into a clamped screen cursor position with button state.
module ps2_mouse_tracker #(
  parameter int          X_W          = 10,
  parameter int          Y_W          = 9,
  parameter int          X_MAX        = 639,
  parameter int          Y_MAX        = 479,
  parameter int          X_INIT       = 320,
  parameter int          Y_INIT       = 240,
  parameter int          SPEED_SHIFT  = 0,
  parameter logic [23:0] RESP_TIMEOUT = 24'd5_000_000,
  parameter logic [19:0] PKT_GAP      = 20'd500_000,
  parameter int          RETRIES      = 3
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic [7:0]     rx_data,
  input  logic           rx_data_en,
  input  logic           cmd_sent,
  input  logic           cmd_timeout,
  output logic [7:0]     cmd_data,
  output logic           cmd_send,
  output logic [X_W-1:0] x_position,
  output logic [Y_W-1:0] y_position,
  output logic           left_btn,
  output logic           right_btn,
  output logic           middle_btn,
  output logic           mousePressed,
  output logic           packet_valid,
  output logic           init_done,
  output logic           error,
  output logic [2:0]     state_dbg
);

  // Handshakes: cmd_send is a level request held until the transceiver
  // answers with a one-cycle cmd_sent or cmd_timeout while cmd_send is high;
  // rx_data is sampled only in the cycle rx_data_en is high.

  typedef enum logic [2:0] {
    RST_SEND, RST_ACK, WAIT_BAT, WAIT_ID, EN_SEND, EN_ACK, STREAM, FAIL
  } state_t;

  localparam int AW = $clog2(RETRIES + 1);
  localparam int SW = ((X_W > Y_W) ? X_W : Y_W) + 13;

  state_t         state, state_next;
  logic           retry;
  logic           is_wait;
  logic [7:0]     exp_byte;
  logic [AW-1:0]  attempts;
  logic [23:0]    timer;
  logic           resp_expired;
  logic           gap_expired;
  logic           cmd_ack;
  logic           cmd_fail;

  logic [1:0]     byte_idx;
  logic [2:0]     hdr_btn;
  logic           hdr_sx, hdr_sy, hdr_ox, hdr_oy;
  logic [7:0]     byte1;

  logic signed [8:0]    dx9, dy9;
  logic signed [SW-1:0] dx_s, dy_s, x_sum, y_sum;
  logic [X_W-1:0]       x_new;
  logic [Y_W-1:0]       y_new;

  assign cmd_ack      = cmd_send && cmd_sent;
  assign cmd_fail     = cmd_send && cmd_timeout && !cmd_sent;
  assign resp_expired = (timer == RESP_TIMEOUT - 24'd1);
  assign gap_expired  = (timer == {4'd0, PKT_GAP});
  assign init_done    = (state == STREAM);
  assign error        = (state == FAIL);
  assign state_dbg    = state;

  always_comb begin
    is_wait  = 1'b0;
    exp_byte = 8'h00;
    case (state)
      RST_ACK:  begin is_wait = 1'b1; exp_byte = 8'hFA; end
      WAIT_BAT: begin is_wait = 1'b1; exp_byte = 8'hAA; end
      WAIT_ID:  begin is_wait = 1'b1; exp_byte = 8'h00; end
      EN_ACK:   begin is_wait = 1'b1; exp_byte = 8'hFA; end
      default:  ;
    endcase
  end

  always_comb begin
    state_next = state;
    retry      = 1'b0;
    case (state)
      RST_SEND: begin
        if (cmd_ack)       state_next = RST_ACK;
        else if (cmd_fail) retry = 1'b1;
      end
      EN_SEND: begin
        if (cmd_ack)       state_next = EN_ACK;
        else if (cmd_fail) retry = 1'b1;
      end
      RST_ACK, WAIT_BAT, WAIT_ID, EN_ACK: begin
        // A byte arriving in the expiry cycle takes precedence over the timeout.
        if (rx_data_en) begin
          if (rx_data != exp_byte) retry = 1'b1;
          else begin
            case (state)
              RST_ACK:  state_next = WAIT_BAT;
              WAIT_BAT: state_next = WAIT_ID;
              WAIT_ID:  state_next = EN_SEND;
              default:  state_next = STREAM;
            endcase
          end
        end else if (resp_expired) begin
          retry = 1'b1;
        end
      end
      default: ;
    endcase
    if (retry) begin
      if (({1'b0, attempts} + (AW+1)'(1)) >= (AW+1)'(RETRIES)) state_next = FAIL;
      else                                                   state_next = RST_SEND;
    end
  end

  // Packet arithmetic: wide signed sum so no clamp decision can be fooled by wrap.
  always_comb begin
    dx9   = hdr_ox ? 9'sd0 : $signed({hdr_sx, byte1});
    dy9   = hdr_oy ? 9'sd0 : $signed({hdr_sy, rx_data});
    dx_s  = SW'(dx9) <<< SPEED_SHIFT;
    dy_s  = SW'(dy9) <<< SPEED_SHIFT;
    x_sum = $signed({{(SW-X_W){1'b0}}, x_position}) + dx_s;
    y_sum = $signed({{(SW-Y_W){1'b0}}, y_position}) - dy_s;
    x_new = x_sum[X_W-1:0];
    y_new = y_sum[Y_W-1:0];
    if (x_sum[SW-1])              x_new = '0;
    else if (x_sum > SW'(X_MAX))  x_new = X_W'(X_MAX);
    if (y_sum[SW-1])              y_new = '0;
    else if (y_sum > SW'(Y_MAX))  y_new = Y_W'(Y_MAX);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= RST_SEND;
      attempts     <= '0;
      timer        <= '0;
      cmd_send     <= 1'b0;
      cmd_data     <= 8'h00;
      byte_idx     <= 2'd0;
      hdr_btn      <= 3'b000;
      hdr_sx       <= 1'b0;
      hdr_sy       <= 1'b0;
      hdr_ox       <= 1'b0;
      hdr_oy       <= 1'b0;
      byte1        <= 8'h00;
      x_position   <= X_W'(X_INIT);
      y_position   <= Y_W'(Y_INIT);
      left_btn     <= 1'b0;
      right_btn    <= 1'b0;
      middle_btn   <= 1'b0;
      mousePressed <= 1'b0;
      packet_valid <= 1'b0;
    end else begin
      state <= state_next;
      if (retry) attempts <= attempts + AW'(1);

      if ((state_next != state) || rx_data_en) timer <= '0;
      else if (timer != '1)                    timer <= timer + 24'd1;

      // Request drops for at least one cycle on every entry or retry.
      cmd_send <= (state_next == state) && !retry &&
                  ((state == RST_SEND) || (state == EN_SEND));
      if (state_next == EN_SEND)       cmd_data <= 8'hF4;
      else if (state_next == RST_SEND) cmd_data <= 8'hFF;

      packet_valid <= 1'b0;
      mousePressed <= 1'b0;
      if (state != STREAM) begin
        byte_idx <= 2'd0;
      end else if (rx_data_en) begin
        case (byte_idx)
          2'd0: begin
            // Bit 3 is always set in a header byte; use it to resynchronise.
            if (rx_data[3]) begin
              hdr_btn  <= rx_data[2:0];
              hdr_sx   <= rx_data[4];
              hdr_sy   <= rx_data[5];
              hdr_ox   <= rx_data[6];
              hdr_oy   <= rx_data[7];
              byte_idx <= 2'd1;
            end
          end
          2'd1: begin
            byte1    <= rx_data;
            byte_idx <= 2'd2;
          end
          default: begin
            x_position   <= x_new;
            y_position   <= y_new;
            left_btn     <= hdr_btn[0];
            right_btn    <= hdr_btn[1];
            middle_btn   <= hdr_btn[2];
            mousePressed <= hdr_btn[0] & ~left_btn;
            packet_valid <= 1'b1;
            byte_idx     <= 2'd0;
          end
        endcase
      end else if ((byte_idx != 2'd0) && gap_expired) begin
        byte_idx <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Bench for ps2_mouse_tracker: init handshake, retries/failure, and a table of
// movement packets checked through an expected-result queue.
module tb_ps2_mouse_tracker;

  localparam logic [23:0] RESP_TO = 24'd200;
  localparam logic [19:0] GAP     = 20'd40;
  localparam int          EW      = 32 + 10 + 9 + 3 + 1;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_data_en = 1'b0;
  logic       cmd_sent = 1'b0;
  logic       cmd_timeout = 1'b0;
  logic [7:0] cmd_data;
  logic       cmd_send;
  logic [9:0] x_position;
  logic [8:0] y_position;
  logic       left_btn, right_btn, middle_btn;
  logic       mousePressed, packet_valid, init_done, error;
  logic [2:0] state_dbg;

  ps2_mouse_tracker #(
    .RESP_TIMEOUT(RESP_TO),
    .PKT_GAP     (GAP)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_data_en  (rx_data_en),
    .cmd_sent    (cmd_sent),
    .cmd_timeout (cmd_timeout),
    .cmd_data    (cmd_data),
    .cmd_send    (cmd_send),
    .x_position  (x_position),
    .y_position  (y_position),
    .left_btn    (left_btn),
    .right_btn   (right_btn),
    .middle_btn  (middle_btn),
    .mousePressed(mousePressed),
    .packet_valid(packet_valid),
    .init_done   (init_done),
    .error       (error),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic [7:0] b0, b1, b2;
    logic [9:0] x;
    logic [8:0] y;
    logic [2:0] btn;   // {middle, right, left}
    logic       press;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge CLOCK_50) begin
    logic [EW-1:0] e, a;
    if (packet_valid) begin
      checks++;
      a = {32'(cyc), x_position, y_position, middle_btn, right_btn, left_btn, mousePressed};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pkt_unexpected: packet_valid at cycle %0d x=%0d y=%0d", cyc, x_position, y_position);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL pkt: got cyc=%0d x=%0d y=%0d btn=%b press=%b, expected cyc=%0d x=%0d y=%0d btn=%b press=%b",
                   a[EW-1:EW-32], a[22:13], a[12:4], a[3:1], a[0],
                   e[EW-1:EW-32], e[22:13], e[12:4], e[3:1], e[0]);
        end
      end
    end
    if (mousePressed && !packet_valid) begin
      checks++;
      errors++;
      $display("FAIL stray_press: mousePressed=1 without packet at cycle %0d, expected 0", cyc);
    end
  end

  // cmd_send episode counter
  int   episodes = 0;
  int   rise_cyc[$];
  logic send_prev = 1'b0;
  always @(negedge CLOCK_50) begin
    if (cmd_send && !send_prev) begin
      episodes++;
      rise_cyc.push_back(cyc);
    end
    send_prev = cmd_send;
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data    = b;
    rx_data_en = 1'b1;
    @(negedge CLOCK_50);
    rx_data_en = 1'b0;
  endtask

  task automatic send_pkt(input vec_t v);
    send_byte(v.b0);
    send_byte(v.b1);
    exp_q.push_back({32'(cyc + 1), v.x, v.y, v.btn, v.press});
    send_byte(v.b2);
  endtask

  task automatic wait_cmd(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (cmd_send) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLOCK_50);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_cmd: cmd_send=0 after %0d cycles, expected 1", budget);
    end
  endtask

  task automatic do_cmd(input logic [7:0] exp_cmd, input bit ack);
    bit ok;
    wait_cmd(RESP_TO + 50, ok);
    if (ok) begin
      check("cmd_data", 64'(cmd_data), 64'(exp_cmd));
      idle(2);
      if (ack) cmd_sent = 1'b1;
      else     cmd_timeout = 1'b1;
      @(negedge CLOCK_50);
      cmd_sent    = 1'b0;
      cmd_timeout = 1'b0;
      check("cmd_send_drop", 64'(cmd_send), 64'd0);
    end
  endtask

  task automatic normal_init();
    do_cmd(8'hFF, 1'b1);
    send_byte(8'hFA);
    send_byte(8'hAA);
    send_byte(8'h00);
    do_cmd(8'hF4, 1'b1);
    check("init_pending", 64'(init_done), 64'd0);
    send_byte(8'hFA);
    idle(1);
    check("init_done", 64'(init_done), 64'd1);
    check("init_error", 64'(error), 64'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    int  base;
    bit  ok;
    bit  any_high;
    int  d;

    vecs[0]  = '{8'h08, 8'h05, 8'h03, 10'd325, 9'd237, 3'b000, 1'b0};
    vecs[1]  = '{8'h18, 8'h00, 8'h89, 10'd69,  9'd100, 3'b000, 1'b0};
    vecs[2]  = '{8'h18, 8'hC0, 8'h00, 10'd5,   9'd100, 3'b000, 1'b0};
    vecs[3]  = '{8'h19, 8'hF6, 8'h00, 10'd0,   9'd100, 3'b001, 1'b1};
    vecs[4]  = '{8'h09, 8'h01, 8'h01, 10'd1,   9'd99,  3'b001, 1'b0};
    vecs[5]  = '{8'hC8, 8'h7F, 8'h7F, 10'd1,   9'd99,  3'b000, 1'b0};
    vecs[6]  = '{8'h08, 8'hFF, 8'hFF, 10'd256, 9'd0,   3'b000, 1'b0};
    vecs[7]  = '{8'h2C, 8'hFF, 8'h00, 10'd511, 9'd256, 3'b100, 1'b0};
    vecs[8]  = '{8'h08, 8'h7F, 8'h00, 10'd638, 9'd256, 3'b000, 1'b0};
    vecs[9]  = '{8'h2B, 8'h7F, 8'hE0, 10'd639, 9'd288, 3'b011, 1'b1};
    vecs[10] = '{8'h28, 8'h00, 8'h00, 10'd639, 9'd479, 3'b000, 1'b0};
    vecs[11] = '{8'h18, 8'h00, 8'h00, 10'd383, 9'd479, 3'b000, 1'b0};

    // reset state
    idle(3);
    check("rst_cmd_send", 64'(cmd_send), 64'd0);
    check("rst_cmd_data", 64'(cmd_data), 64'h00);
    check("rst_x", 64'(x_position), 64'd320);
    check("rst_y", 64'(y_position), 64'd240);
    check("rst_btn", 64'({middle_btn, right_btn, left_btn}), 64'd0);
    check("rst_pulses", 64'({packet_valid, mousePressed}), 64'd0);
    check("rst_flags", 64'({init_done, error}), 64'd0);
    reset = 1'b0;

    // normal bring-up: exactly two command episodes
    normal_init();
    idle(2);
    check("init_episodes", 64'(episodes), 64'd2);

    // movement table
    foreach (vecs[i]) begin
      send_pkt(vecs[i]);
      idle($urandom_range(0, 3));
    end

    // resync: 00 is not a header and must be dropped
    send_byte(8'h00);
    send_pkt('{8'h08, 8'h10, 8'h20, 10'd399, 9'd447, 3'b000, 1'b0});
    // idle gap of exactly PKT_GAP keeps the partial packet
    send_byte(8'h08);
    idle(int'(GAP));
    send_byte(8'h01);
    exp_q.push_back({32'(cyc + 1), 10'd400, 9'd446, 3'b000, 1'b0});
    send_byte(8'h01);
    // PKT_GAP+1 idle cycles drops it
    send_byte(8'h08);
    idle(int'(GAP) + 1);
    send_pkt('{8'h08, 8'h01, 8'h01, 10'd401, 9'd445, 3'b000, 1'b0});
    idle(3);
    check("stream_q_empty", 64'(exp_q.size()), 64'd0);

    // reset mid-packet and mid-command
    send_byte(8'h08);
    send_byte(8'h7F);
    reset = 1'b1;
    idle(2);
    check("midpkt_x", 64'(x_position), 64'd320);
    check("midpkt_y", 64'(y_position), 64'd239 + 64'd1);
    check("midpkt_init", 64'(init_done), 64'd0);
    reset = 1'b0;
    wait_cmd(20, ok);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("reset_drops_cmd", 64'(cmd_send), 64'd0);
    reset = 1'b0;

    // retries: command timeout, then a bad BAT byte, then success
    do_cmd(8'hFF, 1'b0);
    do_cmd(8'hFF, 1'b1);
    send_byte(8'hFA);
    send_byte(8'hAB);
    normal_init();
    idle(2);
    check("retry_episodes", 64'(episodes), 64'd7);
    send_pkt('{8'h08, 8'h01, 8'h01, 10'd321, 9'd239, 3'b000, 1'b0});
    idle(3);

    // silent device: three attempts, then FAIL
    reset = 1'b1;
    idle(2);
    base = episodes;
    rise_cyc.delete();
    reset = 1'b0;
    for (int a = 0; a < 3; a++) do_cmd(8'hFF, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < int'(RESP_TO) + 50; i++) begin
      if (error) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLOCK_50);
    end
    check("fail_error", 64'(ok), 64'd1);
    check("fail_init_done", 64'(init_done), 64'd0);
    any_high = 1'b0;
    for (int i = 0; i < 50; i++) begin
      any_high = any_high | cmd_send;
      @(negedge CLOCK_50);
    end
    check("fail_cmd_send_low", 64'(any_high), 64'd0);
    check("fail_error_held", 64'(error), 64'd1);
    check("fail_episodes", 64'(episodes - base), 64'd3);
    for (int k = 1; k < rise_cyc.size(); k++) begin
      d = rise_cyc[k] - rise_cyc[k-1];
      checks++;
      if (d < int'(RESP_TO) || d > int'(RESP_TO) + 10) begin
        errors++;
        $display("FAIL ff_interval: got %0d cycles, expected %0d..%0d", d, RESP_TO, int'(RESP_TO) + 10);
      end
    end
    check("final_q_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_tracker.md
PS2_MOUSE_TRACKER -- requirements
Module: ps2_mouse_tracker

Interface
REQ-001 Parameter X_W, default 10, width of x_position.
REQ-002 Parameter Y_W, default 9, width of y_position.
REQ-003 Parameter X_MAX, default 639, largest legal x_position.
REQ-004 Parameter Y_MAX, default 479, largest legal y_position.
REQ-005 Parameter X_INIT / Y_INIT, default 320 / 240, position after reset.
REQ-006 Parameter SPEED_SHIFT, default 0 (range 0..3), left shift applied to each delta.
REQ-007 Parameter RESP_TIMEOUT, default 24'd5_000_000, cycles to wait for a device response byte.
REQ-008 Parameter PKT_GAP, default 20'd500_000, maximum idle cycles between bytes of one packet.
REQ-009 Parameter RETRIES, default 3, number of init attempts before error.
REQ-010 CLOCK_50  in  1  system clock; all logic on its rising edge.
REQ-011 reset  in  1  synchronous, active-high reset.
REQ-012 rx_data  in  8  byte from PS/2 byte transceiver.
REQ-013 rx_data_en  in  1  one-cycle strobe, rx_data valid.
REQ-014 cmd_sent  in  1  transceiver acknowledges command byte transmitted.
REQ-015 cmd_timeout  in  1  transceiver reports command transmission failure.
REQ-016 cmd_data  out  8  command byte to transceiver.
REQ-017 cmd_send  out  1  command request, level.
REQ-018 x_position  out  X_W  cursor x, 0..X_MAX.
REQ-019 y_position  out  Y_W  cursor y, 0..Y_MAX, 0 = top.
REQ-020 left_btn, right_btn, middle_btn  out  1 each  button state from last valid packet.
REQ-021 mousePressed  out  1  rising-edge pulse of left_btn, one cycle.
REQ-022 packet_valid  out  1  one-cycle pulse per accepted packet.
REQ-023 init_done  out  1  high while in STREAM.
REQ-024 error  out  1  high in FAIL state.

Function
REQ-025 States: RST_SEND, RST_ACK, WAIT_BAT, WAIT_ID, EN_SEND, EN_ACK, STREAM, FAIL.
REQ-026 RST_SEND: cmd_data=8'hFF, cmd_send=1 until cmd_sent (-> RST_ACK) or cmd_timeout (-> retry); cmd_send deasserted the cycle after either.
REQ-027 RST_ACK expects 8'hFA -> WAIT_BAT; WAIT_BAT expects 8'hAA -> WAIT_ID; WAIT_ID expects 8'h00 -> EN_SEND.
REQ-028 EN_SEND: cmd_data=8'hF4, same handshake as REQ-026 -> EN_ACK; EN_ACK expects 8'hFA -> STREAM.
REQ-029 Any unexpected byte, cmd_timeout, or RESP_TIMEOUT cycles without rx_data_en in a wait state = retry: attempt counter +1, go to RST_SEND after cmd_send low at least one cycle.
REQ-030 Attempt counter reaching RETRIES -> FAIL; FAIL holds cmd_send=0, error=1 until reset.
REQ-031 Response timer clears on state entry and on every rx_data_en.
REQ-032 STREAM: byte index 0..2; byte0 accepted only if bit3=1, else discarded, index stays 0.
REQ-033 Index returns to 0 when more than PKT_GAP cycles elapse between bytes of a partial packet; partial bytes dropped.
REQ-034 dx = 9-bit two's complement {byte0[4], byte1}; dy = {byte0[5], byte2}.
REQ-035 byte0[6] (X overflow) forces dx=0; byte0[7] (Y overflow) forces dy=0; buttons still update.
REQ-036 Scaled delta = delta << SPEED_SHIFT, sign-extended; sum computed at width max(X_W,Y_W)+13 signed, no intermediate overflow.
REQ-037 x_next = x + dx; y_next = y - dy (device y up, screen y down).
REQ-038 Each result clamped: <0 -> 0, >MAX -> MAX.
REQ-039 Latency: x_position, y_position, buttons and packet_valid update on the cycle after the rx_data_en of byte2.
REQ-040 Buttons: left=byte0[0], right=byte0[1], middle=byte0[2].
REQ-041 mousePressed=1 for exactly the cycle left_btn changes 0->1.
REQ-042 rx_data_en outside wait/STREAM states ignored; rx_data_en and timeout same cycle: byte wins.

Reset
REQ-043 On reset: state RST_SEND, attempts 0, index 0, timers 0, x=X_INIT, y=Y_INIT, buttons 0, mousePressed 0, packet_valid 0, init_done 0, error 0, cmd_send 0, cmd_data 8'h00.
REQ-044 Reset mid-packet or mid-command discards everything; cmd_send low the cycle after reset asserted.

Verification
REQ-045 Normal init: cmd_sent after FF, bytes FA,AA,00, cmd_sent after F4, byte FA -> init_done=1, error=0, exactly two cmd_send episodes.
REQ-046 Packet 08,05,03 from (320,240) -> (325,237), packet_valid one pulse one cycle after third strobe.
REQ-047 Packet 19,F6,00 from (5,100) -> x=0 clamp (dx=-10), left_btn=1, mousePressed one pulse; overflow packet C8,7F,7F -> position unchanged.
REQ-048 Resync: bytes 00,08,10,20 in STREAM -> first byte dropped, packet (08,10,20) gives dx=+16, dy=+32.
REQ-049 No device response, RETRIES=3 -> three FF attempts each RESP_TIMEOUT apart, then error=1, cmd_send=0 held.
REQ-050 Gap: byte 08, PKT_GAP+1 idle cycles, then 08,01,01 -> one packet, dx=+1, dy=+1.
